// File: rtl/encoder_pri_rr.sv
// encoder_pri_rr: registered N-to-W request encoder with valid/ready handshake.
// Modes: fixed priority (highest index wins) or round-robin from rr_ptr.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   req_i [N-1:0]   - request vector, bit k is index k
//   mode_i          - 0 fixed priority, 1 round-robin (sampled at capture)
//   in_valid/ready  - upstream handshake
//   out_code [W-1:0]- encoded winner index
//   out_none        - captured vector was all zeros
//   out_valid/ready - downstream handshake
//   out_err         - (ENCODER_PRI_RR_ONEHOT_ERR_EN only) two or more bits set
// Optional feature macro: ENCODER_PRI_RR_ONEHOT_ERR_EN
module encoder_pri_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_code,
    output logic         out_none,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ENCODER_PRI_RR_ONEHOT_ERR_EN
    ,
    output logic         out_err
`endif
);

    logic [W-1:0] rr_ptr;
    logic [W-1:0] fix_code;
    logic [W-1:0] rr_code;
    logic [W-1:0] rr_next;
    logic [W-1:0] sel_code;
    logic         any_req;
    logic         capture;

    assign any_req  = |req_i;
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // Fixed priority: later (higher) indices overwrite earlier ones.
    always_comb begin
        fix_code = '0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) fix_code = W'(k);
        end
    end

    // Round-robin: scan upward from rr_ptr, wrapping at N (not 2^W).
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        rr_code = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found   = 1'b1;
                rr_code = W'(j);
            end
        end
    end

    assign rr_next  = (rr_code == W'(N - 1)) ? '0 : rr_code + 1'b1;
    assign sel_code = mode_i ? rr_code : fix_code;

`ifdef ENCODER_PRI_RR_ONEHOT_ERR_EN
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    logic multi;
    assign multi = |(req_i & (req_i - 1'b1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_none  <= 1'b0;
            rr_ptr    <= '0;
`ifdef ENCODER_PRI_RR_ONEHOT_ERR_EN
            out_err   <= 1'b0;
`endif
        end else begin
            if (capture) begin
                out_valid <= 1'b1;
                out_code  <= any_req ? sel_code : '0;
                out_none  <= !any_req;
`ifdef ENCODER_PRI_RR_ONEHOT_ERR_EN
                out_err   <= multi;
`endif
                // A zero vector leaves the pointer where it was.
                if (mode_i && any_req) rr_ptr <= rr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
